syscall_unit: RTL and testbench
===============================

# syscall_unit

Sequential responder for the `syscall` control point raised by the instruction decoder of the pipelined MIPS CPU. It samples `$v0`/`$a0` when a syscall instruction retires and acts on the call code:
- Halt code: freeze the pipeline until the operator presses resume.
- Any other code: latch `$a0` onto the board display and count the call.

It also keeps a run-cycle counter for the statistics display. It sits beside the WB stage and drives the global stall.

## Interface
Parameters:
- `HALT_CODE`, 10, `$v0` value that halts the CPU.
- `CNT_W`, 32, width of `cycle_cnt`.
- `SC_W`, 16, width of `syscall_cnt`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `syscall_valid`  in  1  one-cycle pulse: a syscall instruction retires this cycle.
- `v0`  in  32  `$v0` value for the retiring syscall; sampled only when `syscall_valid`=1.
- `a0`  in  32  `$a0` value for the retiring syscall; sampled only when `syscall_valid`=1.
- `go`  in  1  resume button level, already debounced and synchronous to `clk`.
- `halted`  out  1  registered; 1 while in HALT.
- `stall_req`  out  1  registered; equal to `halted`; freezes PC and pipeline registers.
- `display_data`  out  32  last `$a0` printed.
- `display_valid`  out  1  one-cycle pulse when `display_data` updates.
- `cycle_cnt`  out  `CNT_W`  cycles spent in RUN.
- `syscall_cnt`  out  `SC_W`  number of non-halt syscalls serviced.

## Operation
- Two states: RUN and HALT. Reset state is RUN.
- Reset values: `halted`=0, `stall_req`=0, `display_data`=0, `display_valid`=0, `cycle_cnt`=0, `syscall_cnt`=0, `go_q`=0.
- `go_q` is a registered copy of `go`. `go_rise` = `go` & ~`go_q`. `go_q` updates every cycle in both states.

In RUN:
- `syscall_valid`=1 and `v0`==`HALT_CODE` → HALT. `display_data` and `syscall_cnt` are unchanged.
- `syscall_valid`=1 and `v0`!=`HALT_CODE`:
  - `display_data` ← `a0`.
  - `display_valid`=1 for exactly one cycle.
  - `syscall_cnt` += 1, wrapping modulo 2^`SC_W`.
- `go_rise` is ignored.

In HALT:
- `syscall_valid` is ignored entirely: no latch, no count, no pulse. The CPU is stalled, so a pulse here is spurious.
- `go_rise` → RUN.
- A `go` level already high when HALT is entered does not resume. A fresh rising edge is required.

Counters and other rules:
- `cycle_cnt` increments by 1 on every clock edge where the current state is RUN. It saturates at 2^`CNT_W`−1 (no wrap). It holds in HALT.
- `display_valid` is 0 in every cycle that is not a serviced print.
- Reset asserted mid-HALT returns to RUN at once and clears all counters and the display. Reset is asynchronous, so outputs change without waiting for a clock edge.

## Timing
- Halt latency: `syscall_valid` with `v0`=`HALT_CODE` sampled at edge N gives `halted`=`stall_req`=1 from edge N until the resume edge.
  - The pipeline controller must tolerate one cycle of post-syscall advance.
- `cycle_cnt` counts edge N: the sampling cycle is in RUN.
- Resume latency: `go` goes 0→1 and is sampled high at edge M, with `go_q`=0. `halted` drops after edge M. `cycle_cnt` resumes counting at edge M+1.
- Print latency: `syscall_valid` at edge N gives `display_data`, `syscall_cnt` and `display_valid`=1 valid after edge N. `display_valid` returns to 0 after edge N+1 unless another print is sampled at N+1.
- Back-to-back print syscalls on consecutive edges: each one is serviced. `display_valid` stays high and `syscall_cnt` increments each cycle.
- Simultaneous `go_rise` and a halt syscall in RUN: the result is HALT. The `go` edge is consumed by `go_q`, so a new press is needed to resume.
- No combinational path from inputs to outputs.

## Test plan
- Reset, then idle 5 cycles → `cycle_cnt`=5, `halted`=0, `display_valid`=0, `display_data`=0.
- Print pulse `v0`=1, `a0`=0x0000_00AB → next cycle `display_data`=0xAB, `display_valid`=1 for one cycle, `syscall_cnt`=1. Then three back-to-back prints → `syscall_cnt`=4, `display_valid` high 3 consecutive cycles.
- Halt pulse `v0`=10 at cycle 20 → `halted`=`stall_req`=1 from cycle 21. `cycle_cnt` frozen at its cycle-20 value+1. A print pulse during HALT changes nothing.
- Halt entered with `go` held high → stays HALT. `go` low for 1 cycle then high → `halted`=0 the following cycle, and `cycle_cnt` restarts counting.
- Same-cycle `go_rise` plus halt syscall → HALT, no resume until a new `go` edge.
- Preload `cycle_cnt` near max with a small `CNT_W`=4 → it saturates at 15. `syscall_cnt` with `SC_W`=2 wraps 3→0. `rst` pulsed mid-HALT, asynchronously between edges → `halted`=0 and counters=0 before the next edge.

Source files
------------

// File: rtl/syscall_unit.sv
// Syscall responder beside WB: halts on the halt code, prints $a0 otherwise,
// and keeps run-cycle and syscall statistics for the board display.
module syscall_unit #(
  parameter logic [31:0] HALT_CODE = 32'd10,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned SC_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             syscall_valid,
  input  logic [31:0]      v0,
  input  logic [31:0]      a0,
  input  logic             go,
  output logic             halted,
  output logic             stall_req,
  output logic [31:0]      display_data,
  output logic             display_valid,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [SC_W-1:0]  syscall_cnt
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic go_q;
  logic go_rise;
  logic is_halt;
  logic do_print;
  logic cnt_max;

  assign go_rise = go & ~go_q;
  assign is_halt = (v0 == HALT_CODE);
  assign cnt_max = &cycle_cnt;

  always_comb begin
    state_d  = state_q;
    do_print = 1'b0;
    unique case (state_q)
      RUN: begin
        if (syscall_valid) begin
          if (is_halt) state_d  = HALT;
          else         do_print = 1'b1;
        end
      end
      HALT: begin
        if (go_rise) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      go_q    <= go;
    end
  end

  // halted/stall_req mirror the next state so they rise on the sampling edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted    <= 1'b0;
      stall_req <= 1'b0;
    end else begin
      halted    <= (state_d == HALT);
      stall_req <= (state_d == HALT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      display_data  <= '0;
      display_valid <= 1'b0;
      syscall_cnt   <= '0;
    end else begin
      display_valid <= do_print;
      if (do_print) begin
        display_data <= a0;
        syscall_cnt  <= syscall_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if (state_q == RUN && !cnt_max) begin
      cycle_cnt <= cycle_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_syscall_unit.sv
// Directed bench for syscall_unit: full-size instance plus a narrow
// instance for counter saturation and wrap.
module tb_syscall_unit;

  logic        clk;
  logic        rst;
  logic        sv;
  logic [31:0] v0;
  logic [31:0] a0;
  logic        go;
  logic        halted;
  logic        stall_req;
  logic [31:0] dd;
  logic        dv;
  logic [31:0] cyc;
  logic [15:0] sc;

  logic        sv_s;
  logic [31:0] v0_s;
  logic [31:0] a0_s;
  logic        go_s;
  logic        halted_s;
  logic        stall_s;
  logic [31:0] dd_s;
  logic        dv_s;
  logic [3:0]  cyc_s;
  logic [1:0]  sc_s;

  int pass;
  int total;
  int ecyc;
  bit ehalt;

  syscall_unit u_dut (
    .clk           (clk),
    .rst           (rst),
    .syscall_valid (sv),
    .v0            (v0),
    .a0            (a0),
    .go            (go),
    .halted        (halted),
    .stall_req     (stall_req),
    .display_data  (dd),
    .display_valid (dv),
    .cycle_cnt     (cyc),
    .syscall_cnt   (sc)
  );

  syscall_unit #(
    .HALT_CODE (32'd10),
    .CNT_W     (4),
    .SC_W      (2)
  ) u_small (
    .clk           (clk),
    .rst           (rst),
    .syscall_valid (sv_s),
    .v0            (v0_s),
    .a0            (a0_s),
    .go            (go_s),
    .halted        (halted_s),
    .stall_req     (stall_s),
    .display_data  (dd_s),
    .display_valid (dv_s),
    .cycle_cnt     (cyc_s),
    .syscall_cnt   (sc_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one clock; expected run-cycle count follows the bench's own state flag
  task automatic step();
    @(posedge clk);
    #1;
    if (!ehalt) ecyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sv = 0; v0 = 0; a0 = 0; go = 0;
    sv_s = 0; v0_s = 0; a0_s = 0; go_s = 0;
    ehalt = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    ecyc = 0;
    total++;
    if (cyc !== 32'd0 || halted !== 1'b0 || dv !== 1'b0)
      $display("FAIL reset_state cyc=%0d halted=%b dv=%b", cyc, halted, dv);
    else pass++;
    repeat (5) step();
    total++;
    if (cyc !== 32'd5 || halted !== 1'b0 || stall_req !== 1'b0 ||
        dv !== 1'b0 || dd !== 32'd0 || sc !== 16'd0)
      $display("FAIL idle5 cyc=%0d h=%b dv=%b dd=%h sc=%0d want 5/0/0/0/0",
               cyc, halted, dv, dd, sc);
    else pass++;
  endtask

  task automatic test_print();
    sv = 1; v0 = 32'd1; a0 = 32'h0000_00AB;
    step();
    sv = 0;
    total++;
    if (dd !== 32'hAB || dv !== 1'b1 || sc !== 16'd1)
      $display("FAIL print1 dd=%h dv=%b sc=%0d want ab/1/1", dd, dv, sc);
    else pass++;
    step();
    total++;
    if (dv !== 1'b0 || dd !== 32'hAB)
      $display("FAIL print1_pulse dv=%b dd=%h want 0/ab", dv, dd);
    else pass++;
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) begin
      sv = 1; v0 = 32'd4; a0 = 32'h100 + i;
      step();
      total++;
      if (dv !== 1'b1 || sc !== 16'(1 + i) || dd !== 32'h100 + i)
        $display("FAIL b2b_%0d dv=%b sc=%0d dd=%h want 1/%0d/%h",
                 i, dv, sc, dd, 1 + i, 32'h100 + i);
      else pass++;
    end
    sv = 0;
    step();
    total++;
    if (dv !== 1'b0 || sc !== 16'd4 || dd !== 32'h103)
      $display("FAIL b2b_end dv=%b sc=%0d dd=%h want 0/4/103", dv, sc, dd);
    else pass++;
  endtask

  task automatic test_halt();
    int frozen;
    sv = 1; v0 = 32'd10; a0 = 32'hDEAD;
    step();
    ehalt = 1;
    sv = 0;
    frozen = ecyc;
    total++;
    if (halted !== 1'b1 || stall_req !== 1'b1 || cyc !== frozen ||
        dv !== 1'b0 || dd !== 32'h103 || sc !== 16'd4)
      $display("FAIL halt_enter h=%b s=%b cyc=%0d dv=%b dd=%h sc=%0d want 1/1/%0d/0/103/4",
               halted, stall_req, cyc, dv, dd, sc, frozen);
    else pass++;
    sv = 1; v0 = 32'd1; a0 = 32'h55;
    step();
    sv = 0;
    step();
    total++;
    if (halted !== 1'b1 || cyc !== frozen || dv !== 1'b0 ||
        dd !== 32'h103 || sc !== 16'd4)
      $display("FAIL halt_print h=%b cyc=%0d dv=%b dd=%h sc=%0d want 1/%0d/0/103/4",
               halted, cyc, dv, dd, sc, frozen);
    else pass++;
    go = 1;
    step();
    ehalt = 0;
    go = 0;
    total++;
    if (halted !== 1'b0 || stall_req !== 1'b0 || cyc !== frozen)
      $display("FAIL resume h=%b s=%b cyc=%0d want 0/0/%0d",
               halted, stall_req, cyc, frozen);
    else pass++;
    step();
    total++;
    if (cyc !== frozen + 1)
      $display("FAIL resume_count cyc=%0d want %0d", cyc, frozen + 1);
    else pass++;
  endtask

  task automatic test_go_held();
    go = 1;
    step();
    sv = 1; v0 = 32'd10;
    step();
    ehalt = 1;
    sv = 0;
    repeat (3) step();
    total++;
    if (halted !== 1'b1 || cyc !== ecyc)
      $display("FAIL go_held h=%b cyc=%0d want 1/%0d", halted, cyc, ecyc);
    else pass++;
    go = 0;
    step();
    go = 1;
    step();
    ehalt = 0;
    total++;
    if (halted !== 1'b0)
      $display("FAIL go_held_resume h=%b want 0", halted);
    else pass++;
    go = 0;
    step();
    total++;
    if (cyc !== ecyc)
      $display("FAIL go_held_count cyc=%0d want %0d", cyc, ecyc);
    else pass++;
  endtask

  task automatic test_simultaneous();
    go = 1; sv = 1; v0 = 32'd10;
    step();
    ehalt = 1;
    sv = 0;
    repeat (2) step();
    total++;
    if (halted !== 1'b1 || stall_req !== 1'b1)
      $display("FAIL simul_halt h=%b s=%b want 1/1", halted, stall_req);
    else pass++;
    go = 0;
    step();
    go = 1;
    step();
    ehalt = 0;
    go = 0;
    total++;
    if (halted !== 1'b0 || cyc !== ecyc)
      $display("FAIL simul_resume h=%b cyc=%0d want 0/%0d", halted, cyc, ecyc);
    else pass++;
  endtask

  task automatic test_small();
    total++;
    if (cyc_s !== 4'd15)
      $display("FAIL sat cyc_s=%0d want 15", cyc_s);
    else pass++;
    step();
    total++;
    if (cyc_s !== 4'd15)
      $display("FAIL sat_hold cyc_s=%0d want 15", cyc_s);
    else pass++;
    sv_s = 1; v0_s = 32'd1;
    for (int i = 1; i <= 3; i++) begin
      a0_s = i;
      step();
    end
    total++;
    if (sc_s !== 2'd3)
      $display("FAIL wrap_pre sc_s=%0d want 3", sc_s);
    else pass++;
    a0_s = 32'h4;
    step();
    sv_s = 0;
    total++;
    if (sc_s !== 2'd0 || dd_s !== 32'h4 || dv_s !== 1'b1)
      $display("FAIL wrap sc_s=%0d dd_s=%h dv_s=%b want 0/4/1", sc_s, dd_s, dv_s);
    else pass++;
  endtask

  task automatic test_async_reset();
    sv = 1; v0 = 32'd10;
    step();
    ehalt = 1;
    sv = 0;
    total++;
    if (halted !== 1'b1)
      $display("FAIL ar_halt h=%b want 1", halted);
    else pass++;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (halted !== 1'b0 || stall_req !== 1'b0 || cyc !== 32'd0 ||
        sc !== 16'd0 || dd !== 32'd0 || cyc_s !== 4'd0)
      $display("FAIL async_rst h=%b s=%b cyc=%0d sc=%0d dd=%h cyc_s=%0d want all 0",
               halted, stall_req, cyc, sc, dd, cyc_s);
    else pass++;
    #1;
    rst = 1'b0;
    ehalt = 0;
    ecyc = 0;
    step();
    total++;
    if (cyc !== 32'd1 || halted !== 1'b0)
      $display("FAIL post_rst cyc=%0d h=%b want 1/0", cyc, halted);
    else pass++;
  endtask

  initial begin
    pass  = 0;
    total = 0;
    ecyc  = 0;
    test_reset();
    test_print();
    test_back_to_back();
    test_halt();
    test_go_held();
    test_simultaneous();
    test_small();
    test_async_reset();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
